// File: rtl/data_ram.sv
// Byte-array memories for the RV32I core: data_ram serves MEM-stage loads/stores,
// instruction_ram serves fetch with a flush override.
module data_ram #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_SIZE_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           data_in,
   input  logic                  write,
   input  logic                  read,
   input  logic [2:0]            funct3,
   output logic                  data_access_fault_exception,
   output logic [31:0]           data_out
);

   localparam int RAM_BYTES = 1 << RAM_SIZE_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH+1)'(RAM_BYTES - 1);

   logic [DATA_WIDTH-1:0]     mem [RAM_BYTES];
   logic [2:0]                size;
   logic [ADDR_WIDTH:0]       end_addr;
   logic                      bad_funct3;
   logic                      fault;
   logic [RAM_SIZE_WIDTH-1:0] base;
   logic [31:0]               raw_word;

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b010:  return raw;
         3'b100:  return {24'd0, raw[7:0]};
         3'b101:  return {16'd0, raw[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      case (funct3[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
   end

   // One extra bit on the end address so accesses near the top of the bus never wrap.
   assign end_addr   = {1'b0, address} + (ADDR_WIDTH+1)'(size) - (ADDR_WIDTH+1)'(1);
   assign bad_funct3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   assign fault      = bad_funct3 || (end_addr > LAST_BYTE);
   assign base       = address[RAM_SIZE_WIDTH-1:0];

   assign raw_word = {mem[base + RAM_SIZE_WIDTH'(3)], mem[base + RAM_SIZE_WIDTH'(2)],
                      mem[base + RAM_SIZE_WIDTH'(1)], mem[base]};

   // Storage is never cleared; a store is dropped while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst_n && write && !fault) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(size))
               mem[base + RAM_SIZE_WIDTH'(k)] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out                    <= '0;
         data_access_fault_exception <= 1'b0;
      end else if (write) begin
         data_access_fault_exception <= fault;
      end else if (read) begin
         data_access_fault_exception <= fault;
         data_out                    <= fault ? 32'd0 : extend_load(funct3, raw_word);
      end
   end

endmodule

module instruction_ram #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_SIZE_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [31:0]           instruction_in,
   input  logic                  instruction_write,
   input  logic                  flush,
   output logic [31:0]           instruction
);

   localparam int RAM_BYTES = 1 << RAM_SIZE_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH+1)'(RAM_BYTES - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [DATA_WIDTH-1:0]     mem [RAM_BYTES];
   logic [ADDR_WIDTH:0]       end_addr;
   logic                      fault;
   logic [RAM_SIZE_WIDTH-1:0] base;
   logic [31:0]               fetch_word;

   assign end_addr = {1'b0, PC} + (ADDR_WIDTH+1)'(3);
   assign fault    = end_addr > LAST_BYTE;
   assign base     = PC[RAM_SIZE_WIDTH-1:0];

   assign fetch_word = {mem[base + RAM_SIZE_WIDTH'(3)], mem[base + RAM_SIZE_WIDTH'(2)],
                        mem[base + RAM_SIZE_WIDTH'(1)], mem[base]};

   always_ff @(posedge clk) begin
      if (rst_n && instruction_write && !fault) begin
         for (int k = 0; k < 4; k++)
            mem[base + RAM_SIZE_WIDTH'(k)] <= instruction_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Nonblocking update makes a same-cycle write invisible to this fetch (read-first).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instruction <= NOP;
      else if (flush || fault)
         instruction <= NOP;
      else
         instruction <= fetch_word;
   end

endmodule

// File: tb/tb_data_ram.sv
// Directed scoreboard bench for data_ram and its companion instruction_ram.
module tb_data_ram;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
   localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [2:0]  funct3 = 3'b010;
   logic        data_access_fault_exception;
   logic [31:0] data_out;

   logic [31:0] pc = '0;
   logic [31:0] instruction_in = '0;
   logic        instruction_write = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] instruction;

   typedef struct {
      string       tag;
      logic [31:0] value;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   int          n_total = 0;
   int          n_pass = 0;
   logic [31:0] last_dout = '0;

   data_ram dut (
      .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
      .write(write), .read(read), .funct3(funct3),
      .data_access_fault_exception(data_access_fault_exception), .data_out(data_out)
   );

   instruction_ram iram (
      .clk(clk), .rst_n(rst_n), .PC(pc), .instruction_in(instruction_in),
      .instruction_write(instruction_write), .flush(flush), .instruction(instruction)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] din,
                         input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] exp_dout, input logic exp_fault);
      exp_t e;
      sb.push_back('{tag, exp_dout, exp_fault});
      @(negedge clk);
      address = addr; data_in = din; write = wr; read = rd; funct3 = f3;
      @(posedge clk);
      #1;
      write = 1'b0; read = 1'b0;
      if (sb.size() == 0) begin
         check32({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check32({e.tag, "_dout"}, data_out, e.value);
         check32({e.tag, "_fault"}, {31'd0, data_access_fault_exception}, {31'd0, e.fault});
      end
      last_dout = exp_dout;
   endtask

   task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] din,
                        input logic [2:0] f3, input logic exp_fault);
      mem_op(tag, addr, din, 1'b1, 1'b0, f3, last_dout, exp_fault);
   endtask

   task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] exp, input logic exp_fault);
      mem_op(tag, addr, 32'd0, 1'b0, 1'b1, f3, exp, exp_fault);
   endtask

   task automatic fetch(input string tag, input logic [31:0] p, input logic [31:0] win,
                        input logic we, input logic fl, input logic chk, input logic [31:0] exp);
      exp_t e;
      if (chk) sb.push_back('{tag, exp, 1'b0});
      @(negedge clk);
      pc = p; instruction_in = win; instruction_write = we; flush = fl;
      @(posedge clk);
      #1;
      instruction_write = 1'b0;
      if (chk) begin
         e = sb.pop_front();
         check32(e.tag, instruction, e.value);
      end
   endtask

   initial begin
      // Reset held across two edges.
      repeat (2) @(posedge clk);
      #1;
      check32("rst_dout", data_out, 32'd0);
      check32("rst_fault", {31'd0, data_access_fault_exception}, 32'd0);
      check32("rst_instr", instruction, NOP);
      @(negedge clk);
      rst_n = 1'b1;

      // Top-of-memory boundaries.
      store("sw_65532", 32'd65532, 32'hAABBCCDD, F_W, 1'b0);
      store("sw_65533", 32'd65533, 32'h11111111, F_W, 1'b1);
      mem_op("idle_fault_hold", 32'd0, 32'd0, 1'b0, 1'b0, F_W, last_dout, 1'b1);
      store("sh_65535", 32'd65535, 32'h11111111, F_H, 1'b1);
      store("sb_65536", 32'd65536, 32'h11111111, F_B, 1'b1);
      load("lw_65532_unchanged", 32'd65532, F_W, 32'hAABBCCDD, 1'b0);
      load("lb_65535", 32'd65535, F_B, 32'hFFFFFFAA, 1'b0);
      load("lw_65533_fault", 32'd65533, F_W, 32'd0, 1'b1);
      load("bad_funct3", 32'd0, F_BAD, 32'd0, 1'b1);

      // Byte accesses.
      store("sb_100", 32'd100, 32'h12345678, F_B, 1'b0);
      load("lb_100", 32'd100, F_B, 32'h00000078, 1'b0);
      store("sb_101", 32'd101, 32'h34567812, F_B, 1'b0);
      load("lb_101", 32'd101, F_B, 32'h00000012, 1'b0);
      store("sb_102", 32'd102, 32'h56781234, F_B, 1'b0);
      load("lb_102", 32'd102, F_B, 32'h00000034, 1'b0);
      store("sb_103", 32'd103, 32'h78123456, F_B, 1'b0);
      load("lb_103", 32'd103, F_B, 32'h00000056, 1'b0);
      load("lw_100_bytes", 32'd100, F_W, 32'h56341278, 1'b0);
      store("sb_80", 32'd100, 32'h00000080, F_B, 1'b0);
      load("lb_80", 32'd100, F_B, 32'hFFFFFF80, 1'b0);
      load("lbu_80", 32'd100, F_BU, 32'h00000080, 1'b0);

      // Halfword accesses, including odd alignment.
      store("sh_104", 32'd104, 32'h12345678, F_H, 1'b0);
      load("lh_104", 32'd104, F_H, 32'h00005678, 1'b0);
      store("sh_109", 32'd109, 32'h34567812, F_H, 1'b0);
      load("lh_109", 32'd109, F_H, 32'h00007812, 1'b0);
      store("sh_114", 32'd114, 32'h56781234, F_H, 1'b0);
      load("lh_114", 32'd114, F_H, 32'h00001234, 1'b0);
      store("sh_119", 32'd119, 32'h78123456, F_H, 1'b0);
      load("lh_119", 32'd119, F_H, 32'h00003456, 1'b0);
      store("sh_8001", 32'd104, 32'h00008001, F_H, 1'b0);
      load("lh_8001", 32'd104, F_H, 32'hFFFF8001, 1'b0);
      load("lhu_8001", 32'd104, F_HU, 32'h00008001, 1'b0);

      // Word accesses at every alignment.
      store("sw_124", 32'd124, 32'h12345678, F_W, 1'b0);
      load("lw_124", 32'd124, F_W, 32'h12345678, 1'b0);
      store("sw_129", 32'd129, 32'h34567812, F_W, 1'b0);
      load("lw_129", 32'd129, F_W, 32'h34567812, 1'b0);
      store("sw_134", 32'd134, 32'h56781234, F_W, 1'b0);
      load("lw_134", 32'd134, F_W, 32'h56781234, 1'b0);
      store("sw_139", 32'd139, 32'h78123456, F_W, 1'b0);
      load("lw_139", 32'd139, F_W, 32'h78123456, 1'b0);
      mem_op("idle_dout_hold", 32'd124, 32'd0, 1'b0, 1'b0, F_W, last_dout, 1'b0);

      // Store wins over a simultaneous load.
      mem_op("sw_rd_both", 32'd200, 32'hCAFEBABE, 1'b1, 1'b1, F_W, last_dout, 1'b0);
      load("lw_200", 32'd200, F_W, 32'hCAFEBABE, 1'b0);

      // Instruction memory.
      fetch("if_w0", 32'd0, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'd0);
      fetch("if_w4", 32'd4, 32'h22222222, 1'b1, 1'b0, 1'b0, 32'd0);
      fetch("if_w8", 32'd8, 32'h33333333, 1'b1, 1'b0, 1'b0, 32'd0);
      fetch("if_r0", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h11111111);
      fetch("if_r4", 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 32'h22222222);
      fetch("if_r8", 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h33333333);
      fetch("if_flush", 32'd8, 32'd0, 1'b0, 1'b1, 1'b1, NOP);
      fetch("if_unflush", 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h33333333);
      fetch("if_oob", 32'd65533, 32'd0, 1'b0, 1'b0, 1'b1, NOP);
      fetch("if_oob_write", 32'd65534, 32'h55555555, 1'b1, 1'b0, 1'b1, NOP);
      fetch("if_read_first", 32'd4, 32'h44444444, 1'b1, 1'b0, 1'b1, 32'h22222222);
      fetch("if_after_write", 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 32'h44444444);
      fetch("if_r8_again", 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h33333333);

      // Asynchronous reset between clock edges.
      store("sb_fault_pre_rst", 32'd70000, 32'd0, F_B, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check32("async_rst_dout", data_out, 32'd0);
      check32("async_rst_fault", {31'd0, data_access_fault_exception}, 32'd0);
      check32("async_rst_instr", instruction, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      last_dout = '0;
      load("lw_200_post_rst", 32'd200, F_W, 32'hCAFEBABE, 1'b0);
      fetch("if_r8_post_rst", 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, 32'h33333333);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_ram.md
# data_ram

Byte-addressed, little-endian data memory for the RISC-V core's MEM stage. It performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) at any byte alignment and flags out-of-range accesses. The same file provides the companion `instruction_ram`, the fetch-stage memory. It shares the byte-array organisation and adds a 32-bit fetch port with a pipeline-flush override.

## Interface
Parameters (both modules):
- DATA_WIDTH, 8, width of one storage element (byte).
- ADDR_WIDTH, 32, width of the address/PC bus.
- RAM_SIZE_WIDTH, 16, memory holds 2^RAM_SIZE_WIDTH bytes (65536).

data_ram ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- address  in  ADDR_WIDTH  byte address of the access.
- data_in  in  32  store data; low byte/halfword used for SB/SH.
- write  in  1  store enable.
- read  in  1  load enable.
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_access_fault_exception  out  1  registered fault flag.
- data_out  out  32  registered, extended load result.

instruction_ram ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- PC  in  ADDR_WIDTH  fetch/write byte address.
- instruction_in  in  32  word to store.
- instruction_write  in  1  store enable (loader path).
- flush  in  1  force NOP on output.
- instruction  out  32  registered fetched word.

## Operation
- Storage is an array of 2^RAM_SIZE_WIDTH DATA_WIDTH-bit bytes. It is not cleared by reset.
- Little-endian: byte k of a word is at address+k. No alignment requirement; misaligned H/W accesses are legal.
- Access size is 1 for funct3[1:0]=00, 2 for 01, and 4 for 10.
- Fault condition: address + size − 1 > 2^RAM_SIZE_WIDTH − 1. Compute it in ADDR_WIDTH+1 bits so it cannot wrap. funct3 values 011, 110 and 111 also fault.
- Store (write=1, no fault): write the low `size` bytes of data_in to address..address+size−1.
- A faulting store writes nothing.
- Load (read=1, no fault):
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW returns the full 4 bytes.
- A faulting load sets data_out to 0.
- If write and read are both 1, the store wins and no load is performed; data_out holds.
- data_access_fault_exception updates on every cycle with write or read asserted, to that access's fault result. It holds its value on idle cycles.
- data_out updates only on non-faulting loads (and to 0 on faulting loads); it holds otherwise.

instruction_ram:
- Each cycle, `instruction` loads the 4 bytes at PC..PC+3 (little-endian).
- If the PC range exceeds memory, `instruction` loads 0x00000013.
- flush=1 overrides both cases and loads 0x00000013 (addi x0,x0,0).
- instruction_write=1 stores instruction_in at PC..PC+3. Out-of-range writes are ignored.
- On a simultaneous read and write to the same PC, the read returns the old contents (read-first).

## Timing
- Reset (async assert, sync release):
  - data_out=0 and data_access_fault_exception=0.
  - instruction=0x00000013.
- Store: memory updated at the rising edge on which write=1; visible to a load issued in the next cycle.
- Load latency is 1 cycle: data_out is valid after the edge that sampled read=1 and stays stable until the next load.
- Fault flag is valid after the edge that sampled the access.
- Fetch latency is 1 cycle. Flush takes effect at the next edge and releases at the next edge after flush drops.
- Reset mid-access aborts it; no partial store is guaranteed.

## Test plan
- SW 0x11111111 at 65533 -> fault=1, memory unchanged. SH at 65535 -> fault=1. SB at 65536 -> fault=1. SW at 65532 -> fault=0.
- SB data_in 0x12345678/0x34567812/0x56781234/0x78123456 at 100/101/102/103, each followed by LB -> data_out 0x78/0x12/0x34/0x56. Then SB 0x80 followed by LB -> 0xFFFFFF80; LBU -> 0x00000080.
- SH same four values at 104/109/114/119, each followed by LH -> 0x5678/0x7812/0x1234/0x3456. SH 0x8001 followed by LH -> 0xFFFF8001; LHU -> 0x00008001.
- SW same four values at 124/129/134/139, each followed by LW -> data_out equals data_in. data_out holds after read drops.
- instruction_ram: write 0x11111111/0x22222222/0x33333333 at PC 0/4/8, then fetch each -> matching word one cycle later. flush=1 -> 0x00000013; flush=0 -> 0x33333333 returns.
- Assert rst_n low mid-sequence -> all outputs go to their reset values immediately, without waiting for a clock edge.
